// File: rtl/dpram_arbiter.sv
// Two-requester req/ack arbiter in front of port A of a dual-port RAM (registered address, combinational dout).
// Build option: define DPRAM_ARB_FIXED_PRIO_EN for fixed priority (rq0 wins ties); default is round robin.
module dpram_arbiter #(
  parameter int  DATA_SIZE  = 64,
  parameter int  DATA_WIDTH = 8,
  localparam int ADDR_W     = $clog2(DATA_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rq0_req,
  input  logic                  rq0_we,
  input  logic [ADDR_W-1:0]     rq0_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,
  output logic                  rq0_ack,
  output logic [DATA_WIDTH-1:0] rq0_rdata,
  input  logic                  rq1_req,
  input  logic                  rq1_we,
  input  logic [ADDR_W-1:0]     rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,
  output logic                  rq1_ack,
  output logic [DATA_WIDTH-1:0] rq1_rdata,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  req_v     [2];
  logic                  we_v      [2];
  logic [ADDR_W-1:0]     addr_v    [2];
  logic [DATA_WIDTH-1:0] wdata_v   [2];
  logic                  ack_q     [2];
  logic [DATA_WIDTH-1:0] rdata_q   [2];
  logic [1:0]            elig;
  logic                  win_id;
  logic                  grant_en;
  logic                  capture_en;

  logic                  lat_we_q, lat_we_d;
  logic                  lat_id_q, lat_id_d;
  logic [ADDR_W-1:0]     lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;

  assign req_v[0]   = rq0_req;
  assign req_v[1]   = rq1_req;
  assign we_v[0]    = rq0_we;
  assign we_v[1]    = rq1_we;
  assign addr_v[0]  = rq0_addr;
  assign addr_v[1]  = rq1_addr;
  assign wdata_v[0] = rq0_wdata;
  assign wdata_v[1] = rq1_wdata;

  // A requester whose ack is showing this cycle is masked so one access never gets two grants.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req_v[gi] & ~ack_q[gi];
    end
  endgenerate

  assign grant_en = (state_q == IDLE) && (elig != 2'b00);

`ifdef DPRAM_ARB_FIXED_PRIO_EN
  assign win_id = ~elig[0];
`else
  logic last_q, last_d;

  assign win_id = (elig == 2'b11) ? ~last_q : ~elig[0];
  assign last_d = capture_en ? lat_id_q : last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    lat_we_d    = lat_we_q;
    lat_id_d    = lat_id_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    if (grant_en) begin
      lat_we_d    = we_v[win_id];
      lat_id_d    = win_id;
      lat_addr_d  = addr_v[win_id];
      lat_wdata_d = wdata_v[win_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we_q    <= 1'b0;
      lat_id_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      lat_we_q    <= lat_we_d;
      lat_id_q    <= lat_id_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (elig != 2'b00) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM address always follows the latch, so only the write strobe depends on state.
  always_comb begin
    ram_we     = 1'b0;
    capture_en = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE:    busy = 1'b0;
      ISSUE:   ram_we = lat_we_q & ~rst;
      CAPTURE: capture_en = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign ram_addr_a = lat_addr_q;
  assign ram_din_a  = lat_wdata_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic hit;
      assign hit = capture_en && (lat_id_q == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          ack_q[gi]   <= 1'b0;
          rdata_q[gi] <= '0;
        end else begin
          ack_q[gi] <= hit;
          if (hit) rdata_q[gi] <= ram_dout_a;
        end
      end
    end
  endgenerate

  assign rq0_ack   = ack_q[0];
  assign rq1_ack   = ack_q[1];
  assign rq0_rdata = rdata_q[0];
  assign rq1_rdata = rdata_q[1];

endmodule
